// File: rtl/rr_select.sv
// rr_select: round-robin pick of the first eligible index at or after ptr
module rr_select #(
    parameter int N = 4,
    parameter int I = $clog2(N)
) (
    input  logic [N-1:0] eligible_i,
    input  logic [I-1:0] ptr_i,
    output logic [I-1:0] winner_o,
    output logic         any_o
);
    logic [2*N-1:0] rot;
    logic [I:0]     off;
    logic [I:0]     sum;
    // rotate a doubled mask so ptr lands at bit 0, priority-encode, then undo the rotation
    always_comb begin
        rot = {eligible_i, eligible_i} >> ptr_i;
        off = '0;
        for (int k = N - 1; k >= 0; k--) off = rot[k] ? (I+1)'(k) : off;
        sum = off + {1'b0, ptr_i};
        winner_o = (sum >= (I+1)'(N)) ? I'(sum - (I+1)'(N)) : I'(sum);
        any_o = |eligible_i;
    end
endmodule

// File: rtl/arbitrate.sv
// arbitrate: packet-aware round-robin merge of N streams into one {index, data} stream
module arbitrate #(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N*W-1:0]          s_data,
    input  logic [N-1:0]            s_last,
    input  logic [N-1:0]            s_valid,
    output logic [N-1:0]            s_ready,
    output logic [$clog2(N)+W-1:0]  m_data,
    output logic                    m_last,
    output logic                    m_valid,
    input  logic                    m_ready
);
    localparam int I = $clog2(N);
    logic [I-1:0]   ptr_q, ptr_d, owner_q, owner_d, winner;
    logic           locked_q, locked_d, m_last_q, m_last_d, m_valid_q, m_valid_d;
    logic [I+W-1:0] m_data_q, m_data_d;
    logic [N-1:0]   eligible;
    logic           any, load, take;
    // a held lock narrows the candidates to the packet owner
    always_comb begin
        load = !m_valid_q || m_ready;
        eligible = locked_q ? (s_valid & (N'(1) << owner_q)) : s_valid;
        take = load && any;
    end
    rr_select #(.N(N), .I(I)) u_sel (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .winner_o   (winner),
        .any_o      (any)
    );
    // grant the winner and compute the next output beat, lock and pointer
    always_comb begin
        s_ready = (take && rst) ? (N'(1) << winner) : '0;
        ptr_d = ptr_q;
        owner_d = owner_q;
        locked_d = locked_q;
        m_data_d = m_data_q;
        m_last_d = m_last_q;
        m_valid_d = load ? 1'b0 : m_valid_q;
        if (take) begin
            m_data_d = {winner, s_data[winner*W +: W]};
            m_last_d = s_last[winner];
            m_valid_d = 1'b1;
            locked_d = !s_last[winner];
            owner_d = s_last[winner] ? owner_q : winner;
            ptr_d = !s_last[winner] ? ptr_q : (winner == I'(N - 1)) ? '0 : winner + 1'b1;
        end
    end
    // state and output registers; reset drops any buffered beat and lock
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
            owner_q <= '0;
            locked_q <= 1'b0;
            m_data_q <= '0;
            m_last_q <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            owner_q <= owner_d;
            locked_q <= locked_d;
            m_data_q <= m_data_d;
            m_last_q <= m_last_d;
            m_valid_q <= m_valid_d;
        end
    end
    assign m_data = m_data_q;
    assign m_last = m_last_q;
    assign m_valid = m_valid_q;
endmodule

// File: tb/tb_arbitrate.sv
// tb_arbitrate: randomized and directed checks of arbitrate against a queue-based model
module tb_arbitrate;
    localparam int W = 8;
    localparam int N = 4;
    localparam int I = 2;
    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N*W-1:0] s_data = '0;
    logic [N-1:0]   s_last = '0;
    logic [N-1:0]   s_valid = '0;
    logic [N-1:0]   s_ready;
    logic [I+W-1:0] m_data;
    logic           m_last;
    logic           m_valid;
    logic           m_ready = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [W-1:0] qd[N][$];
    logic         ql[N][$];
    logic [W:0]   sb[N][$];
    int           ptr, owner;
    bit           locked, e_valid, e_last;
    logic [I+W-1:0] e_data;

    arbitrate #(.W(W), .N(N)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_last(s_last), .s_valid(s_valid),
        .s_ready(s_ready), .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int ch, input logic [W-1:0] d, input logic l);
        qd[ch].push_back(d);
        ql[ch].push_back(l);
        sb[ch].push_back({l, d});
    endtask

    function automatic int outstanding();
        int n = 0;
        for (int i = 0; i < N; i++) n += sb[i].size();
        return n;
    endfunction

    task automatic do_reset();
        s_valid = '0;
        rst = 1'b0;
        #1;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_last", m_last, 0);
        check("rst_s_ready", s_ready, 0);
        ptr = 0; owner = 0; locked = 0; e_valid = 0; e_last = 0; e_data = '0;
        for (int i = 0; i < N; i++) begin
            qd[i].delete(); ql[i].delete(); sb[i].delete();
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic step(input logic [N-1:0] vm, input logic mr);
        int w, idx, j;
        bit load, el;
        logic [N-1:0] er;
        for (int i = 0; i < N; i++) begin
            s_valid[i] = vm[i] && qd[i].size() > 0;
            s_data[i*W +: W] = qd[i].size() > 0 ? qd[i][0] : '0;
            s_last[i] = ql[i].size() > 0 ? ql[i][0] : 1'b0;
        end
        m_ready = mr;
        #1;
        if (m_valid && m_ready) begin
            idx = int'(m_data[I+W-1:W]);
            check("lb_avail", sb[idx].size() > 0, 1);
            if (sb[idx].size() > 0) check("lb_word", {m_last, m_data[W-1:0]}, sb[idx].pop_front());
        end
        load = !e_valid || mr;
        w = -1;
        for (int k = 0; k < N; k++) begin
            j = (ptr + k) % N;
            el = locked ? (j == owner && s_valid[j]) : s_valid[j];
            if (el && w < 0) w = j;
        end
        er = (load && w >= 0) ? N'(1) << w : '0;
        check("s_ready", s_ready, er);
        if (load && w >= 0) begin
            e_data = {I'(w), qd[w].pop_front()};
            e_last = ql[w].pop_front();
            e_valid = 1;
            if (e_last) begin
                locked = 0;
                ptr = (w + 1) % N;
            end else begin
                locked = 1;
                owner = w;
            end
        end else if (load) e_valid = 0;
        @(posedge clk);
        @(negedge clk);
        check("m_valid", m_valid, e_valid);
        if (e_valid) begin
            check("m_data", m_data, e_data);
            check("m_last", m_last, e_last);
        end
    endtask

    initial begin
        logic [I+W-1:0] seq2[5];
        int cyc;
        seq2 = '{'h010, 'h111, 'h212, 'h313, 'h014};
        #1;
        do_reset();
        // single requester, then show the pointer moved past ch2
        push(2, 8'h5A, 1'b1);
        step(4'b0100, 1'b1);
        check("t1_data", m_data, 'h25A);
        push(0, 8'h01, 1'b1);
        push(3, 8'h03, 1'b1);
        step(4'b1001, 1'b1);
        check("t1_ptr", m_data, 'h303);
        step(4'b1001, 1'b1);
        step(4'b0000, 1'b1);
        // strict rotation with wrap from ptr 0
        do_reset();
        for (int i = 0; i < N; i++) push(i, 8'h10 + 8'(i), 1'b1);
        push(0, 8'h14, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 1'b1);
            check("t2_seq", m_data, seq2[i]);
        end
        step(4'b0000, 1'b1);
        // packet lock across an owner bubble, then ch3 before ch0
        push(1, 8'hA0, 1'b0);
        push(1, 8'hA1, 1'b0);
        push(1, 8'hA2, 1'b1);
        push(0, 8'h30, 1'b1);
        push(3, 8'h33, 1'b1);
        step(4'b1011, 1'b1);
        step(4'b1001, 1'b1);
        step(4'b1011, 1'b1);
        step(4'b1011, 1'b1);
        step(4'b1011, 1'b1);
        check("t3_ch3", m_data, 'h333);
        step(4'b1011, 1'b1);
        check("t3_ch0", m_data, 'h030);
        step(4'b0000, 1'b1);
        // backpressure holds the buffered beat, release drains and accepts together
        push(3, 8'hFF, 1'b1);
        step(4'b1000, 1'b1);
        check("t4_buf", m_data, 'h3FF);
        push(1, 8'h44, 1'b1);
        repeat (5) step(4'b1010, 1'b0);
        check("t4_hold", m_data, 'h3FF);
        step(4'b1010, 1'b1);
        check("t4_next", m_data, 'h144);
        step(4'b0000, 1'b1);
        // reset in the middle of a ch0 packet
        do_reset();
        push(0, 8'h01, 1'b0);
        push(0, 8'h02, 1'b0);
        push(0, 8'h03, 1'b1);
        step(4'b0001, 1'b1);
        step(4'b0001, 1'b1);
        do_reset();
        push(3, 8'h77, 1'b1);
        step(4'b1000, 1'b1);
        check("t5_ch3", m_data, 'h377);
        step(4'b0000, 1'b1);
        // random packets with bubbles and backpressure, delivered per channel in order
        for (int c = 0; c < N; c++)
            for (int b = 0; b < 8; b++)
                push(c, 8'($urandom), (b == 7) || ($urandom_range(0, 2) == 0));
        cyc = 0;
        while ((outstanding() > 0 || e_valid) && cyc < 3000) begin
            step(N'($urandom), $urandom_range(0, 3) != 0);
            cyc++;
        end
        check("t6_drained", outstanding() + int'(e_valid), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
